wb_result_queue: RTL and testbench

- Per-functional-unit writeback holding queue between an execute unit (ALU, MDU or DMEM) and the CDB arbiter.
- Accepts one writeback_packet_t per cycle from its FU and presents the oldest pending result to the CDB as a request.
- Retires that result when the arbiter grants it.
- Absorbs CDB contention so FUs stall only when the queue is full.
- Supports zero-latency bypass when empty, and a pipeline flush.

---
 rtl/uarch_pkg.sv | 16 +
 rtl/wb_result_queue_mem.sv | 33 +++
 rtl/wb_result_queue.sv | 96 +++++++++
 tb/tb_wb_result_queue.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/uarch_pkg.sv
// Shared micro-architecture types: the writeback packet carried from the
// execute units to the CDB, and sizing shared by the writeback queues.
package uarch_pkg;

  localparam int PIPE_WIDTH = 32;
  localparam int ROB_TAG_W  = 6;
  localparam int WBQ_DEPTH  = 4;

  typedef struct packed {
    logic                  is_valid;
    logic [ROB_TAG_W-1:0]  rob_tag;
    logic [4:0]            dest_reg;
    logic [PIPE_WIDTH-1:0] data;
  } writeback_packet_t;

endpackage

// File: rtl/wb_result_queue_mem.sv
// Packet storage for the writeback queue: DEPTH registers, one write port,
// asynchronous read at the head index.
module wbq_fifo_mem
  import uarch_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_idx,
  input  writeback_packet_t wr_data,
  input  logic [AW-1:0]     rd_idx,
  output writeback_packet_t rd_data
);

  writeback_packet_t mem_r [DEPTH];

  // Entry storage; reset clears every slot so no stale valid bit survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en) begin
      mem_r[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/wb_result_queue.sv
// Per-FU writeback holding queue in front of the CDB arbiter: FIFO of results
// with optional zero-latency bypass when empty and a synchronous flush.
module wb_result_queue
  import uarch_pkg::*;
#(
  parameter int DEPTH  = WBQ_DEPTH,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  writeback_packet_t          fu_result,
  output logic                       fu_ready,
  output writeback_packet_t          cdb_req,
  input  logic                       cdb_gnt,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0]     head_r;
  logic [AW-1:0]     tail_r;
  logic [CW-1:0]     count_r;
  writeback_packet_t head_pkt_s;
  writeback_packet_t cdb_req_s;
  logic              empty_s;
  logic              ready_s;
  logic              push_s;
  logic              pop_s;
  logic              write_s;
  logic              store_pop_s;

  assign empty_s = (count_r == {CW{1'b0}});
  // Ready looks only at stored state and flush; a grant never feeds back here.
  assign ready_s = (count_r < CW'(DEPTH)) && !flush;
  assign push_s  = fu_result.is_valid && ready_s;
  assign pop_s   = cdb_req_s.is_valid && cdb_gnt;
  // A bypass hit consumes the packet straight from the FU, so it is never stored.
  assign write_s     = push_s && !(empty_s && pop_s);
  assign store_pop_s = pop_s && !empty_s;

  wbq_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (write_s),
    .wr_idx  (tail_r),
    .wr_data (fu_result),
    .rd_idx  (head_r),
    .rd_data (head_pkt_s)
  );

  // Request selection: stored head first, else bypass, gated off by flush/reset.
  always_comb begin
    cdb_req_s = '0;
    if (!rst || flush) begin
      cdb_req_s = '0;
    end else if (!empty_s) begin
      cdb_req_s = head_pkt_s;
    end else if (BYPASS != 0) begin
      cdb_req_s = fu_result;
    end else begin
      cdb_req_s = '0;
    end
  end

  // Pointer and count bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else if (flush) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (write_s) begin
        tail_r <= tail_r + AW'(1);
      end
      if (store_pop_s) begin
        head_r <= head_r + AW'(1);
      end
      case ({write_s, store_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign fu_ready  = ready_s;
  assign cdb_req   = cdb_req_s;
  assign occupancy = count_r;

endmodule

// File: tb/tb_wb_result_queue.sv
// Self-checking bench for wb_result_queue: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_wb_result_queue;
  import uarch_pkg::*;

  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH + 1);

  logic                  clk;
  logic                  rst;
  logic                  flush;
  writeback_packet_t     fu_result;
  logic                  fu_ready;
  writeback_packet_t     cdb_req;
  logic                  cdb_gnt;
  logic [OW-1:0]         occupancy;

  int checks;
  int errors;
  writeback_packet_t model_q [$];

  wb_result_queue #(.DEPTH(DEPTH), .BYPASS(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .fu_result (fu_result),
    .fu_ready  (fu_ready),
    .cdb_req   (cdb_req),
    .cdb_gnt   (cdb_gnt),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic cyc(input logic v, input logic [ROB_TAG_W-1:0] tag,
                     input logic g, input logic f);
    writeback_packet_t p;
    writeback_packet_t exp_req;
    logic exp_rdy;
    logic push;
    logic pop;
    p.is_valid = v;
    p.rob_tag  = tag;
    p.dest_reg = 5'($urandom);
    p.data     = $urandom;
    fu_result  = p;
    cdb_gnt    = g;
    flush      = f;
    #2;
    exp_rdy = (model_q.size() < DEPTH) && !f;
    if (f)                       exp_req = '0;
    else if (model_q.size() > 0) exp_req = model_q[0];
    else if (v)                  exp_req = p;
    else                         exp_req = '0;
    chk("fu_ready", 64'(fu_ready), 64'(exp_rdy));
    chk("occupancy", 64'(occupancy), 64'(model_q.size()));
    chk("req_valid", 64'(cdb_req.is_valid), 64'(exp_req.is_valid));
    if (exp_req.is_valid) chk("req_payload", 64'(cdb_req), 64'(exp_req));
    push = v && exp_rdy;
    pop  = exp_req.is_valid && g;
    @(posedge clk);
    #1;
    if (f) begin
      model_q.delete();
    end else begin
      if (push) model_q.push_back(p);
      if (pop)  void'(model_q.pop_front());
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    cdb_gnt   = 1'b0;
    fu_result = '0;
    #2;
    chk("reset_occ", 64'(occupancy), 64'd0);
    chk("reset_ready", 64'(fu_ready), 64'd1);
    chk("reset_req_valid", 64'(cdb_req.is_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Bypass hit: pushed and granted in the same cycle, never stored.
    cyc(1'b1, 6'd7, 1'b1, 1'b0);
    cyc(1'b0, 6'd0, 1'b0, 1'b0);

    // Fill to full without grants.
    for (int k = 1; k <= 4; k++) cyc(1'b1, 6'(k), 1'b0, 1'b0);
    #2;
    chk("full_occ", 64'(occupancy), 64'd4);
    chk("full_ready", 64'(fu_ready), 64'd0);
    chk("full_head_tag", 64'(cdb_req.rob_tag), 64'd1);
    @(posedge clk);
    #1;

    // Single grant from full, then observe and drain.
    cyc(1'b0, 6'd0, 1'b1, 1'b0);
    cyc(1'b0, 6'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 6'd0, 1'b1, 1'b0);

    // Streaming through a partly filled queue so the pointers wrap repeatedly.
    cyc(1'b1, 6'd1, 1'b0, 1'b0);
    cyc(1'b1, 6'd2, 1'b0, 1'b0);
    for (int k = 3; k <= 20; k++) cyc(1'b1, 6'(k), 1'b1, 1'b0);
    cyc(1'b0, 6'd0, 1'b1, 1'b0);
    cyc(1'b0, 6'd0, 1'b1, 1'b0);
    cyc(1'b0, 6'd0, 1'b0, 1'b0);

    // Flush with traffic and grant present.
    for (int k = 30; k < 33; k++) cyc(1'b1, 6'(k), 1'b0, 1'b0);
    cyc(1'b1, 6'd40, 1'b1, 1'b1);
    cyc(1'b0, 6'd0, 1'b1, 1'b0);
    cyc(1'b1, 6'd41, 1'b0, 1'b0);
    cyc(1'b0, 6'd0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a cycle.
    cyc(1'b1, 6'd50, 1'b0, 1'b0);
    cyc(1'b1, 6'd51, 1'b0, 1'b0);
    fu_result = '0;
    cdb_gnt   = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 64'(cdb_req.is_valid), 64'd0);
    chk("async_rst_occ", 64'(occupancy), 64'd0);
    model_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1'b1, 6'd52, 1'b0, 1'b0);
    cyc(1'b0, 6'd0, 1'b1, 1'b0);

    // Random traffic; valid is only offered when the queue can take it.
    for (int n = 0; n < 400; n++) begin
      logic f;
      logic v;
      f = ($urandom_range(0, 15) == 0);
      v = ($urandom_range(0, 2) != 0) && (model_q.size() < DEPTH);
      cyc(v, 6'($urandom), 1'($urandom), f);
    end
    cyc(1'b0, 6'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
